m0_regfile_banked: RTL and testbench

- Parametrised, multi-port successor to the Cortex-M0 register file: general registers R0–R12, banked stack pointer (MSP/PSP), LR and PC.
- Provides NUM_RD combinational read ports, two prioritised write ports, optional write-to-read bypass and a hardware PC incrementer.
- Sits between decode (read addresses) and writeback (ALU result plus load/second result). PC is also exported to fetch.

---
 rtl/m0_pkg.sv | 17 +
 rtl/m0_regfile_banked_if.sv | 35 +++
 rtl/m0_regfile_rdport.sv | 53 +++++
 rtl/m0_regfile_banked.sv | 163 ++++++++++++++++
 tb/tb_m0_regfile_banked.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m0_pkg.sv
// Shared constants and types for the banked Cortex-M0 style register file.
// Ports: none (package).
package m0_pkg;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t REG_SP = 4'd13;
  localparam reg_idx_t REG_LR = 4'd14;
  localparam reg_idx_t REG_PC = 4'd15;

  // R0-R12 live in a plain array; SP/LR/PC are held separately.
  localparam int unsigned NUM_GPR = 13;

  localparam int unsigned PC_INC_16 = 2;
  localparam int unsigned PC_INC_32 = 4;

endpackage

// File: rtl/m0_regfile_banked_if.sv
// Read/write bus between decode/writeback and the register file.
// Signals: rd_addr/rd_data (NUM_RD packed read ports), wr0_* (high-priority
// write), wr1_* (low-priority write). master = pipeline side, slave = regfile.
interface m0_regfile_banked_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NUM_RD = 3
);
  import m0_pkg::*;

  logic [4*NUM_RD-1:0]  rd_addr;
  logic [DW*NUM_RD-1:0] rd_data;

  logic                 wr0_en;
  reg_idx_t             wr0_addr;
  logic [DW-1:0]        wr0_data;

  logic                 wr1_en;
  reg_idx_t             wr1_addr;
  logic [DW-1:0]        wr1_data;

  modport master (
    output rd_addr,
    input  rd_data,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data
  );

endinterface

// File: rtl/m0_regfile_rdport.sv
// One combinational read port: register select with SP bank choice, PC read
// offset and optional same-cycle write bypass.
// Ports: addr/spsel (select), gpr/lr/msp/psp/pc (stored state),
// wr0_*/wr1_* (already-aligned write data for bypass), data (read result).
module m0_regfile_rdport
  import m0_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter bit          BYPASS         = 1'b1,
  parameter int unsigned PC_READ_OFFSET = 4
) (
  input  reg_idx_t                    addr,
  input  logic                        spsel,
  input  logic [NUM_GPR-1:0][DW-1:0]  gpr,
  input  logic [DW-1:0]               lr,
  input  logic [DW-1:0]               msp,
  input  logic [DW-1:0]               psp,
  input  logic [DW-1:0]               pc,
  input  logic                        wr0_en,
  input  reg_idx_t                    wr0_addr,
  input  logic [DW-1:0]               wr0_data,
  input  logic                        wr1_en,
  input  reg_idx_t                    wr1_addr,
  input  logic [DW-1:0]               wr1_data,
  output logic [DW-1:0]               data
);

  logic [DW-1:0] stored;

  // Stored value; R15 reads see the pipeline offset, wrapping modulo 2^DW.
  always_comb begin
    stored = '0;
    case (addr)
      REG_SP:  stored = spsel ? psp : msp;
      REG_LR:  stored = lr;
      REG_PC:  stored = pc + DW'(PC_READ_OFFSET);
      default: stored = gpr[addr];
    endcase
  end

  // Bypass order mirrors write priority; bypassed R15 carries no offset.
  always_comb begin
    data = stored;
    if (BYPASS) begin
      if (wr0_en && (wr0_addr == addr)) begin
        data = wr0_data;
      end else if (wr1_en && (wr1_addr == addr)) begin
        data = wr1_data;
      end
    end
  end

endmodule

// File: rtl/m0_regfile_banked.sv
// Banked Cortex-M0 style register file: R0-R12, MSP/PSP, LR, PC with NUM_RD
// combinational read ports, two prioritised write ports and a PC incrementer.
// Ports: clk, rst (async active-high), bus (read/write interface, slave side),
// spsel (SP bank select), pc_inc_en/pc_inc_4 (PC advance +2/+4),
// pc_out/msp_out/psp_out (state taps), conflict (same-register write last cycle).
module m0_regfile_banked
  import m0_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter int unsigned NUM_RD         = 3,
  parameter bit          BYPASS         = 1'b1,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] RESET_MSP      = 32'h2000_0400,
  parameter int unsigned PC_READ_OFFSET = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  m0_regfile_banked_if.slave   bus,
  input  logic                 spsel,
  input  logic                 pc_inc_en,
  input  logic                 pc_inc_4,
  output logic [DW-1:0]        pc_out,
  output logic [DW-1:0]        msp_out,
  output logic [DW-1:0]        psp_out,
  output logic                 conflict
);

  localparam int unsigned NUM_REGS = 16;

  logic [NUM_GPR-1:0][DW-1:0]  gpr;
  logic [DW-1:0]               lr;
  logic [DW-1:0]               msp;
  logic [DW-1:0]               psp;
  logic [DW-1:0]               pc;

  logic [DW-1:0]               wr0_al;
  logic [DW-1:0]               wr1_al;
  logic                        wr1_keep;
  logic                        same_dst;
  logic [NUM_REGS-1:0]         we;
  logic [NUM_REGS-1:0][DW-1:0] wd;
  logic [NUM_RD-1:0][DW-1:0]   rd_vec;

  // SP writes are word aligned, PC writes halfword aligned.
  function automatic logic [DW-1:0] align_wr(reg_idx_t a, logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (a == REG_SP) begin
      r[1:0] = 2'b00;
    end else if (a == REG_PC) begin
      r[0] = 1'b0;
    end
    return r;
  endfunction

  assign wr0_al   = align_wr(bus.wr0_addr, bus.wr0_data);
  assign wr1_al   = align_wr(bus.wr1_addr, bus.wr1_data);
  // Both ports address the same register name; spsel is common to both, so
  // this is also the same physical register.
  assign same_dst = bus.wr0_en && bus.wr1_en && (bus.wr0_addr == bus.wr1_addr);
  assign wr1_keep = bus.wr1_en && !same_dst;

  // Per-architectural-register write enable and data, wr0 taking precedence.
  always_comb begin
    we = '0;
    wd = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (bus.wr0_en && (bus.wr0_addr == reg_idx_t'(r))) begin
        we[r] = 1'b1;
        wd[r] = wr0_al;
      end else if (wr1_keep && (bus.wr1_addr == reg_idx_t'(r))) begin
        we[r] = 1'b1;
        wd[r] = wr1_al;
      end
    end
  end

  // General registers R0-R12.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_GPR; i++) begin
        if (we[i]) begin
          gpr[i] <= wd[i];
        end
      end
    end
  end

  // Link register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr <= '0;
    end else if (we[REG_LR]) begin
      lr <= wd[REG_LR];
    end
  end

  // Banked stack pointers; only the bank selected at the edge is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msp <= DW'(RESET_MSP);
      psp <= '0;
    end else if (we[REG_SP]) begin
      if (spsel) begin
        psp <= wd[REG_SP];
      end else begin
        msp <= wd[REG_SP];
      end
    end
  end

  // Program counter: explicit write, else increment, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= DW'(RESET_PC);
    end else if (we[REG_PC]) begin
      pc <= wd[REG_PC];
    end else if (pc_inc_en) begin
      pc <= pc + DW'(pc_inc_4 ? PC_INC_32 : PC_INC_16);
    end
  end

  // One-cycle pulse after a dual write to one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= 1'b0;
    end else begin
      conflict <= same_dst;
    end
  end

  assign pc_out  = pc;
  assign msp_out = msp;
  assign psp_out = psp;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    m0_regfile_rdport #(
      .DW             (DW),
      .BYPASS         (BYPASS),
      .PC_READ_OFFSET (PC_READ_OFFSET)
    ) u_rdport (
      .addr     (bus.rd_addr[4*i +: 4]),
      .spsel    (spsel),
      .gpr      (gpr),
      .lr       (lr),
      .msp      (msp),
      .psp      (psp),
      .pc       (pc),
      .wr0_en   (bus.wr0_en),
      .wr0_addr (bus.wr0_addr),
      .wr0_data (wr0_al),
      .wr1_en   (bus.wr1_en),
      .wr1_addr (bus.wr1_addr),
      .wr1_data (wr1_al),
      .data     (rd_vec[i])
    );
  end

  assign bus.rd_data = rd_vec;

endmodule

// File: tb/tb_m0_regfile_banked.sv
// Directed bench for m0_regfile_banked: one bypassing and one non-bypassing
// instance driven by identical stimulus, both with RESET_PC = 0x100.
module tb_m0_regfile_banked;
  import m0_pkg::*;

  logic clk;
  logic rst;
  logic spsel;
  logic pc_inc_en;
  logic pc_inc_4;
  logic [31:0] pc_b, msp_b, psp_b, pc_nb, msp_nb, psp_nb;
  logic conflict_b, conflict_nb;

  int n_checks;
  int n_fail;

  m0_regfile_banked_if #(.DW(32), .NUM_RD(3)) bus_b ();
  m0_regfile_banked_if #(.DW(32), .NUM_RD(3)) bus_nb ();

  assign bus_nb.rd_addr  = bus_b.rd_addr;
  assign bus_nb.wr0_en   = bus_b.wr0_en;
  assign bus_nb.wr0_addr = bus_b.wr0_addr;
  assign bus_nb.wr0_data = bus_b.wr0_data;
  assign bus_nb.wr1_en   = bus_b.wr1_en;
  assign bus_nb.wr1_addr = bus_b.wr1_addr;
  assign bus_nb.wr1_data = bus_b.wr1_data;

  m0_regfile_banked #(
    .DW(32), .NUM_RD(3), .BYPASS(1'b1), .RESET_PC(32'h0000_0100),
    .RESET_MSP(32'h2000_0400), .PC_READ_OFFSET(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .spsel(spsel), .pc_inc_en(pc_inc_en),
    .pc_inc_4(pc_inc_4), .pc_out(pc_b), .msp_out(msp_b), .psp_out(psp_b),
    .conflict(conflict_b)
  );

  m0_regfile_banked #(
    .DW(32), .NUM_RD(3), .BYPASS(1'b0), .RESET_PC(32'h0000_0100),
    .RESET_MSP(32'h2000_0400), .PC_READ_OFFSET(4)
  ) u_dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb), .spsel(spsel), .pc_inc_en(pc_inc_en),
    .pc_inc_4(pc_inc_4), .pc_out(pc_nb), .msp_out(msp_nb), .psp_out(psp_nb),
    .conflict(conflict_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_b(int i);
    return bus_b.rd_data[32*i +: 32];
  endfunction

  function automatic logic [31:0] rd_nb(int i);
    return bus_nb.rd_data[32*i +: 32];
  endfunction

  task automatic set_rd(input reg_idx_t a0, input reg_idx_t a1, input reg_idx_t a2);
    bus_b.rd_addr = {a2, a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1; spsel = 1'b0; pc_inc_en = 1'b0; pc_inc_4 = 1'b0;
    bus_b.wr0_en = 1'b0; bus_b.wr0_addr = '0; bus_b.wr0_data = '0;
    bus_b.wr1_en = 1'b0; bus_b.wr1_addr = '0; bus_b.wr1_data = '0;
    set_rd(4'd0, REG_SP, REG_PC);
    @(posedge clk); #2;
    for (int r = 0; r < 13; r++) begin
      set_rd(4'(r), REG_SP, REG_PC);
      #1;
      n_checks++;
      if (rd_b(0) !== 32'h0) begin
        n_fail++; $display("FAIL reset_r%0d: got %h expected %h", r, rd_b(0), 32'h0);
      end
    end
    n_checks++;
    if (rd_b(1) !== 32'h2000_0400) begin
      n_fail++; $display("FAIL reset_sp: got %h expected %h", rd_b(1), 32'h2000_0400);
    end
    n_checks++;
    if (rd_b(2) !== 32'h0000_0104) begin
      n_fail++; $display("FAIL reset_r15: got %h expected %h", rd_b(2), 32'h104);
    end
    n_checks++;
    if (rd_nb(2) !== 32'h0000_0104) begin
      n_fail++; $display("FAIL reset_r15_nb: got %h expected %h", rd_nb(2), 32'h104);
    end
    n_checks++;
    if (pc_b !== 32'h0000_0100) begin
      n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_b, 32'h100);
    end
    n_checks++;
    if (psp_b !== 32'h0 || msp_b !== 32'h2000_0400 || conflict_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_misc: got psp %h msp %h conflict %b expected 0 20000400 0",
                         psp_b, msp_b, conflict_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b1; bus_b.wr0_addr = 4'd3; bus_b.wr0_data = 32'hABCD_EF01;
    set_rd(4'd3, 4'd0, 4'd0);
    #1;
    n_checks++;
    if (rd_b(0) !== 32'hABCD_EF01) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_b(0), 32'hABCD_EF01);
    end
    n_checks++;
    if (rd_nb(0) !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got %h expected %h", rd_nb(0), 32'h0);
    end
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b0;
    #1;
    n_checks++;
    if (rd_b(0) !== 32'hABCD_EF01) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %h expected %h", rd_b(0), 32'hABCD_EF01);
    end
    n_checks++;
    if (rd_nb(0) !== 32'hABCD_EF01) begin
      n_fail++; $display("FAIL nobypass_next_cycle: got %h expected %h", rd_nb(0), 32'hABCD_EF01);
    end
  endtask

  task automatic test_conflict();
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b1; bus_b.wr0_addr = 4'd5; bus_b.wr0_data = 32'h11;
    bus_b.wr1_en = 1'b1; bus_b.wr1_addr = 4'd5; bus_b.wr1_data = 32'h22;
    set_rd(4'd5, 4'd6, 4'd0);
    #1;
    n_checks++;
    if (rd_b(0) !== 32'h11) begin
      n_fail++; $display("FAIL conflict_bypass: got %h expected %h", rd_b(0), 32'h11);
    end
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b0; bus_b.wr1_en = 1'b0;
    #1;
    n_checks++;
    if (rd_nb(0) !== 32'h11) begin
      n_fail++; $display("FAIL conflict_r5: got %h expected %h", rd_nb(0), 32'h11);
    end
    n_checks++;
    if (conflict_b !== 1'b1) begin
      n_fail++; $display("FAIL conflict_set: got %b expected %b", conflict_b, 1'b1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (conflict_b !== 1'b0) begin
      n_fail++; $display("FAIL conflict_clear: got %b expected %b", conflict_b, 1'b0);
    end
    bus_b.wr0_en = 1'b1; bus_b.wr0_addr = 4'd5; bus_b.wr0_data = 32'h55;
    bus_b.wr1_en = 1'b1; bus_b.wr1_addr = 4'd6; bus_b.wr1_data = 32'h66;
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b0; bus_b.wr1_en = 1'b0;
    #1;
    n_checks++;
    if (rd_nb(0) !== 32'h55 || rd_nb(1) !== 32'h66) begin
      n_fail++; $display("FAIL dual_write: got r5 %h r6 %h expected 55 66", rd_nb(0), rd_nb(1));
    end
    n_checks++;
    if (conflict_b !== 1'b0) begin
      n_fail++; $display("FAIL dual_no_conflict: got %b expected %b", conflict_b, 1'b0);
    end
  endtask

  task automatic test_sp_bank();
    @(posedge clk); #1;
    spsel = 1'b1;
    bus_b.wr0_en = 1'b1; bus_b.wr0_addr = REG_SP; bus_b.wr0_data = 32'h1000_0007;
    set_rd(REG_SP, 4'd0, 4'd0);
    #1;
    n_checks++;
    if (rd_b(0) !== 32'h1000_0004) begin
      n_fail++; $display("FAIL sp_bypass_align: got %h expected %h", rd_b(0), 32'h1000_0004);
    end
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b0;
    #1;
    n_checks++;
    if (psp_b !== 32'h1000_0004 || msp_b !== 32'h2000_0400) begin
      n_fail++; $display("FAIL psp_write: got psp %h msp %h expected 10000004 20000400", psp_b, msp_b);
    end
    n_checks++;
    if (rd_nb(0) !== 32'h1000_0004) begin
      n_fail++; $display("FAIL sp_read_psp: got %h expected %h", rd_nb(0), 32'h1000_0004);
    end
    spsel = 1'b0;
    #1;
    n_checks++;
    if (rd_nb(0) !== 32'h2000_0400) begin
      n_fail++; $display("FAIL sp_read_msp: got %h expected %h", rd_nb(0), 32'h2000_0400);
    end
    bus_b.wr1_en = 1'b1; bus_b.wr1_addr = REG_SP; bus_b.wr1_data = 32'h2000_0103;
    @(posedge clk); #1;
    bus_b.wr1_en = 1'b0;
    n_checks++;
    if (msp_b !== 32'h2000_0100 || psp_b !== 32'h1000_0004) begin
      n_fail++; $display("FAIL msp_write: got msp %h psp %h expected 20000100 10000004", msp_b, psp_b);
    end
  endtask

  task automatic test_pc();
    @(posedge clk); #1;
    set_rd(REG_PC, 4'd0, 4'd0);
    pc_inc_en = 1'b1; pc_inc_4 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (pc_b !== 32'h102) begin
      n_fail++; $display("FAIL pc_inc2: got %h expected %h", pc_b, 32'h102);
    end
    pc_inc_4 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (pc_b !== 32'h106) begin
      n_fail++; $display("FAIL pc_inc4: got %h expected %h", pc_b, 32'h106);
    end
    bus_b.wr0_en = 1'b1; bus_b.wr0_addr = REG_PC; bus_b.wr0_data = 32'h201;
    #1;
    n_checks++;
    if (rd_b(0) !== 32'h200 || rd_nb(0) !== 32'h10A) begin
      n_fail++; $display("FAIL pc_read_during_write: got byp %h nobyp %h expected 200 10a", rd_b(0), rd_nb(0));
    end
    @(posedge clk); #1;
    n_checks++;
    if (pc_b !== 32'h200) begin
      n_fail++; $display("FAIL pc_write_wins: got %h expected %h", pc_b, 32'h200);
    end
    bus_b.wr0_data = 32'hFFFF_FFFE; pc_inc_en = 1'b0;
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b0;
    #1;
    n_checks++;
    if (pc_b !== 32'hFFFF_FFFE || rd_nb(0) !== 32'h2) begin
      n_fail++; $display("FAIL pc_top: got pc %h r15 %h expected fffffffe 2", pc_b, rd_nb(0));
    end
    pc_inc_en = 1'b1; pc_inc_4 = 1'b0;
    @(posedge clk); #1;
    pc_inc_en = 1'b0;
    n_checks++;
    if (pc_b !== 32'h0) begin
      n_fail++; $display("FAIL pc_wrap: got %h expected %h", pc_b, 32'h0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (pc_b !== 32'h0) begin
      n_fail++; $display("FAIL pc_hold: got %h expected %h", pc_b, 32'h0);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b1; bus_b.wr0_addr = 4'd7; bus_b.wr0_data = 32'h77;
    set_rd(4'd7, 4'd0, 4'd0);
    @(posedge clk); #1;
    bus_b.wr0_data = 32'h99;
    #1;
    n_checks++;
    if (rd_nb(0) !== 32'h77 || rd_b(0) !== 32'h99) begin
      n_fail++; $display("FAIL r7_before_reset: got nobyp %h byp %h expected 77 99", rd_nb(0), rd_b(0));
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_nb(0) !== 32'h0) begin
      n_fail++; $display("FAIL async_r7: got %h expected %h", rd_nb(0), 32'h0);
    end
    n_checks++;
    if (pc_b !== 32'h100 || msp_b !== 32'h2000_0400 || psp_b !== 32'h0) begin
      n_fail++; $display("FAIL async_state: got pc %h msp %h psp %h expected 100 20000400 0", pc_b, msp_b, psp_b);
    end
    @(posedge clk); #1;
    bus_b.wr0_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (rd_b(0) !== 32'h0 || pc_b !== 32'h100) begin
      n_fail++; $display("FAIL reset_discards_write: got r7 %h pc %h expected 0 100", rd_b(0), pc_b);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_bypass();
    test_conflict();
    test_sp_bank();
    test_pc();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
